mem_req_queue: RTL and testbench

- Bounded in-order request queue between the trace front end and the DDR5 command scheduler.
- Accepts one parsed request per cycle (time, core, operation, address) and decodes the address into DDR5 fields.
- Presents the oldest request to the scheduler on DRAM-clock boundaries only (CPU:DRAM clock ratio fixed by parameter).
- Drops illegal operation codes and flags them.

---
 rtl/mem_ctrl_pkg.sv | 45 ++++
 rtl/ddr5_addr_decode.sv | 26 ++
 rtl/mem_req_queue.sv | 152 +++++++++++++++
 tb/tb_mem_req_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types: opcode enum, queued request record and DDR5 address-field layout.
// Used by mem_req_queue and ddr5_addr_decode (and the scheduler that follows them).
package mem_ctrl_pkg;

  localparam int ADDR_W    = 36;
  localparam int CPU_CLK_W = 8;
  localparam int CORE_W    = 4;
  localparam int OPN_W     = 3;

  localparam int ROW_MSB    = 35;
  localparam int ROW_LSB    = 20;
  localparam int COL_HI_MSB = 19;
  localparam int COL_HI_LSB = 14;
  localparam int BANK_MSB   = 13;
  localparam int BANK_LSB   = 12;
  localparam int BG_MSB     = 11;
  localparam int BG_LSB     = 9;
  localparam int CHAN_BIT   = 8;
  localparam int COL_LO_MSB = 7;
  localparam int COL_LO_LSB = 6;

  localparam int ROW_W  = ROW_MSB - ROW_LSB + 1;
  localparam int COL_W  = (COL_HI_MSB - COL_HI_LSB + 1) + (COL_LO_MSB - COL_LO_LSB + 1);
  localparam int BANK_W = BANK_MSB - BANK_LSB + 1;
  localparam int BG_W   = BG_MSB - BG_LSB + 1;

  typedef enum logic [1:0] {
    OPN_READ   = 2'd0,
    OPN_WRITE  = 2'd1,
    OPN_IFETCH = 2'd2
  } mem_opn_e;

  typedef struct packed {
    logic [CPU_CLK_W-1:0] cpu_clk;
    logic [CORE_W-1:0]    core;
    mem_opn_e             opn;
    logic [ADDR_W-1:0]    addr;
  } mem_req_t;

  // Codes above OPN_IFETCH are undefined and get dropped at the queue input.
  function automatic logic opn_is_legal(input logic [OPN_W-1:0] opn);
    return opn <= OPN_W'(2);
  endfunction

endpackage

// File: rtl/ddr5_addr_decode.sv
// Combinational split of a physical byte address into DDR5 row/column/bank/bank-group/channel.
// addr[5:0] is the offset within a 64-byte burst and does not reach the DRAM command.
module ddr5_addr_decode
  import mem_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [BANK_W-1:0] bank,
  output logic [BG_W-1:0]   bg,
  output logic              chan
);

  logic [COL_LO_LSB-1:0] unused_burst_offset;

  assign unused_burst_offset = addr[COL_LO_LSB-1:0];

  always_comb begin
    row  = addr[ROW_MSB:ROW_LSB];
    col  = {addr[COL_HI_MSB:COL_HI_LSB], addr[COL_LO_MSB:COL_LO_LSB]};
    bank = addr[BANK_MSB:BANK_LSB];
    bg   = addr[BG_MSB:BG_LSB];
    chan = addr[CHAN_BIT];
  end

endmodule

// File: rtl/mem_req_queue.sv
// In-order request queue between the trace front end and the DDR5 scheduler; pops only on DRAM-clock ticks.
// Optional MEM_REQ_QUEUE_STATS_EN adds max_occupancy and stall_cycles counters.
module mem_req_queue
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 36,
  parameter int CPU_CLK_WIDTH  = 8,
  parameter int CPU_CORE_WIDTH = 4,
  parameter int MEM_OPN_WIDTH  = 3,
  parameter int QUEUE_DEPTH    = 16,
  parameter int CLK_RATIO      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CPU_CLK_WIDTH-1:0]         in_cpu_clk,
  input  logic [CPU_CORE_WIDTH-1:0]        in_core,
  input  logic [MEM_OPN_WIDTH-1:0]         in_opn,
  input  logic [MEM_ADDR_WIDTH-1:0]        in_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [1:0]                       out_opn,
  output logic [CPU_CORE_WIDTH-1:0]        out_core,
  output logic [CPU_CLK_WIDTH-1:0]         out_cpu_clk,
  output logic [15:0]                      out_row,
  output logic [7:0]                       out_col,
  output logic [1:0]                       out_bank,
  output logic [2:0]                       out_bg,
  output logic                             out_chan,
  output logic [$clog2(QUEUE_DEPTH):0]     occupancy,
  output logic                             err_opn
`ifdef MEM_REQ_QUEUE_STATS_EN
  ,
  output logic [$clog2(QUEUE_DEPTH):0]     max_occupancy,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PHASE_W = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;

  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(QUEUE_DEPTH);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_RATIO - 1);

  mem_req_t mem_q [QUEUE_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               err_opn_q, err_opn_d;

  logic     dram_tick, accept, push, pop, empty;
  mem_req_t wr_entry, head;
  logic [ADDR_W-1:0] head_addr;

  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    empty     = (count_q == '0);
    dram_tick = (phase_q == PHASE_LAST);
    // Held low during reset so the scheduler cannot complete a pop on discarded state.
    out_valid = !rst && !empty && dram_tick;
    accept    = in_valid && in_ready;
    push      = accept && opn_is_legal(in_opn);
    pop       = out_valid && out_ready;
    err_opn_d = accept && !opn_is_legal(in_opn);

    wr_entry.cpu_clk = in_cpu_clk;
    wr_entry.core    = in_core;
    wr_entry.opn     = mem_opn_e'(in_opn[1:0]);
    wr_entry.addr    = in_addr;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    phase_d  = dram_tick ? '0 : phase_q + PHASE_W'(1);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      phase_q   <= '0;
      err_opn_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      err_opn_q <= err_opn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // An empty queue presents all-zero head fields rather than stale storage.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    head_addr   = empty ? '0 : head.addr;
    out_opn     = empty ? 2'b00 : head.opn;
    out_core    = empty ? '0 : head.core;
    out_cpu_clk = empty ? '0 : head.cpu_clk;
    occupancy   = count_q;
    err_opn     = err_opn_q;
  end

  ddr5_addr_decode u_addr_decode (
    .addr (head_addr),
    .row  (out_row),
    .col  (out_col),
    .bank (out_bank),
    .bg   (out_bg),
    .chan (out_chan)
  );

`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [CNT_W-1:0] max_occ_q, max_occ_d;
  logic [31:0]      stall_q, stall_d;

  always_comb begin
    max_occ_d = (count_q > max_occ_q) ? count_q : max_occ_q;
    stall_d   = (in_valid && !in_ready && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_occ_q <= '0;
      stall_q   <= '0;
    end else begin
      max_occ_q <= max_occ_d;
      stall_q   <= stall_d;
    end
  end

  assign max_occupancy = max_occ_q;
  assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue: table-driven decode vectors plus FIFO, full, error and reset sequences.
// Stats ports are exercised when MEM_REQ_QUEUE_STATS_EN is defined.
module tb_mem_req_queue;

  localparam int DEPTH = 16;
  localparam int RATIO = 2;

  typedef struct packed {
    logic [1:0]  opn;
    logic [3:0]  core;
    logic [7:0]  t;
    logic [15:0] row;
    logic [7:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
  } exp_t;

  typedef struct {
    logic [35:0] addr;
    logic [2:0]  opn;
    logic [3:0]  core;
    logic [7:0]  t;
    logic [15:0] row;
    logic [7:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_cpu_clk;
  logic [3:0]  in_core;
  logic [2:0]  in_opn;
  logic [35:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_opn;
  logic [3:0]  out_core;
  logic [7:0]  out_cpu_clk;
  logic [15:0] out_row;
  logic [7:0]  out_col;
  logic [1:0]  out_bank;
  logic [2:0]  out_bg;
  logic        out_chan;
  logic [4:0]  occupancy;
  logic        err_opn;
`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [4:0]  max_occupancy;
  logic [31:0] stall_cycles;
`endif

  mem_req_queue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cpu_clk  (in_cpu_clk),
    .in_core     (in_core),
    .in_opn      (in_opn),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opn     (out_opn),
    .out_core    (out_core),
    .out_cpu_clk (out_cpu_clk),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_bank    (out_bank),
    .out_bg      (out_bg),
    .out_chan    (out_chan),
    .occupancy   (occupancy),
    .err_opn     (err_opn)
`ifdef MEM_REQ_QUEUE_STATS_EN
    ,
    .max_occupancy (max_occupancy),
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_count = 0;
  int   m_phase = 0;
  logic m_err = 1'b0;
  int   m_max = 0;
  int   m_stall = 0;
  exp_t sb[$];
  exp_t drv_exp;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks DUT outputs against the reference model at the falling edge, then advances the model.
  task automatic tick();
    exp_t act;
    logic exp_rdy, exp_ov, push, pop;
    @(negedge clk);
    if (rst) begin
      m_count = 0; m_phase = 0; m_err = 1'b0; m_max = 0; m_stall = 0;
      sb.delete();
    end else begin
      exp_rdy = (m_count != DEPTH);
      exp_ov  = (m_count != 0) && (m_phase == RATIO - 1);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("occupancy", 64'(occupancy), 64'(m_count));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("err_opn", 64'(err_opn), 64'(m_err));
      act = {out_opn, out_core, out_cpu_clk, out_row, out_col, out_bank, out_bg, out_chan};
      if (m_count == 0 || sb.size() == 0) chk("head_empty", 64'(act), 64'(0));
      else chk("head", 64'(act), 64'(sb[0]));
`ifdef MEM_REQ_QUEUE_STATS_EN
      chk("max_occupancy", 64'(max_occupancy), 64'(m_max));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      if (m_count > m_max) m_max = m_count;
      if (in_valid && !exp_rdy) m_stall++;
`endif
      push = in_valid && exp_rdy && (in_opn <= 3'd2);
      pop  = exp_ov && out_ready;
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (push) sb.push_back(drv_exp);
      m_err   = in_valid && exp_rdy && (in_opn > 3'd2);
      m_count = m_count + int'(push) - int'(pop);
      m_phase = (m_phase + 1) % RATIO;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] t, input logic [3:0] c, input logic [2:0] o,
                       input logic [35:0] a);
    in_valid   = 1'b1;
    in_cpu_clk = t;
    in_core    = c;
    in_opn     = o;
    in_addr    = a;
    drv_exp    = {o[1:0], c, t, a[35:20], a[19:14], a[7:6], a[13:12], a[11:9], a[8]};
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && m_count != 0; k++) tick();
    tick();
    chk("drain_empty", 64'(occupancy), 64'(0));
  endtask

  initial begin
    // addr, opn, core, t, row, col, bank, bg, chan
    vecs[0] = '{36'h0_1234_5678, 3'd0, 4'd3,  8'd10,  16'h0123, 8'h45, 2'd1, 3'd3, 1'b0};
    vecs[1] = '{36'hF_FFFF_FFFF, 3'd1, 4'd15, 8'd255, 16'hFFFF, 8'hFF, 2'd3, 3'd7, 1'b1};
    vecs[2] = '{36'h0_0000_0000, 3'd1, 4'd0,  8'd0,   16'h0000, 8'h00, 2'd0, 3'd0, 1'b0};
    vecs[3] = '{36'h0_0000_0100, 3'd2, 4'd1,  8'd20,  16'h0000, 8'h00, 2'd0, 3'd0, 1'b1};
    vecs[4] = '{36'h0_0000_0E00, 3'd0, 4'd2,  8'd21,  16'h0000, 8'h00, 2'd0, 3'd7, 1'b0};
    vecs[5] = '{36'h0_0000_3000, 3'd1, 4'd4,  8'd22,  16'h0000, 8'h00, 2'd3, 3'd0, 1'b0};
    vecs[6] = '{36'h0_0000_00C0, 3'd2, 4'd5,  8'd23,  16'h0000, 8'h03, 2'd0, 3'd0, 1'b0};
    vecs[7] = '{36'h0_000F_C000, 3'd0, 4'd6,  8'd24,  16'h0000, 8'hFC, 2'd0, 3'd0, 1'b0};
    vecs[8] = '{36'hA_BCD0_0000, 3'd1, 4'd7,  8'd25,  16'hABCD, 8'h00, 2'd0, 3'd0, 1'b0};
    vecs[9] = '{36'h0_0000_003F, 3'd1, 4'd8,  8'd26,  16'h0000, 8'h00, 2'd0, 3'd0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_cpu_clk = '0; in_core = '0; in_opn = '0; in_addr = '0;
    out_ready = 1'b0; drv_exp = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Decode table: one request at a time, popped as soon as the DRAM tick allows.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      offer(vecs[i].t, vecs[i].core, vecs[i].opn, vecs[i].addr);
      drv_exp = {vecs[i].opn[1:0], vecs[i].core, vecs[i].t, vecs[i].row, vecs[i].col,
                 vecs[i].bank, vecs[i].bg, vecs[i].chan};
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 6 && m_count != 0; k++) tick();
      chk("table_popped", 64'(occupancy), 64'(0));
    end

    // Illegal opcodes are dropped and flagged.
    foreach (vecs[i]) begin
      if (i < 3) begin
        offer(8'd40, 4'd9, (i == 0) ? 3'd5 : ((i == 1) ? 3'd3 : 3'd7), 36'h1_0000_0000);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
      end
    end

    // Fill with out_ready low, then offer a 17th request for 7 stalled cycles.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offer(8'(100 + i), 4'(i), 3'(i % 3), {4'($urandom), 32'($urandom)});
      tick();
    end
    offer(8'd200, 4'd11, 3'd1, 36'h5_5555_5555);
    for (int i = 0; i < 7; i++) tick();
    chk("full_occupancy", 64'(occupancy), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'(0));
`ifdef MEM_REQ_QUEUE_STATS_EN
    chk("stats_max", 64'(max_occupancy), 64'(DEPTH));
    chk("stats_stall", 64'(stall_cycles), 64'(7));
`endif

    // Full and popping on a DRAM tick: the pop happens, the push waits a cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 4 && m_count == DEPTH; k++) tick();
    out_ready = 1'b0;
    chk("full_pop_no_push", 64'(occupancy), 64'(DEPTH - 1));
    tick();
    in_valid = 1'b0;
    chk("refill_after_pop", 64'(occupancy), 64'(DEPTH));
    drain();

    // Reset with five entries queued; the queue restarts from pointer zero.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(8'(50 + i), 4'(i), 3'd0, {4'd3, 32'($urandom)});
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    tick();
    offer(8'd77, 4'd12, 3'd2, 36'h9_8765_4321);
    tick();
    drain();

    // Random traffic, mostly legal.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1)
        offer(8'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0) ? 3'd6 : 3'($urandom_range(0, 2)),
              {4'($urandom), 32'($urandom)});
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
